// File: rtl/eviction_write_buffer_pkg.sv
// Shared types and widths for the eviction write buffer between L2 and the
// cacheline adaptor.
package rv32i_types;

  localparam int LINE_BITS   = 256;
  localparam int OFFSET_BITS = 5;
  localparam int TAG_BITS    = 27;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_MEM = 2'd1,
    DRAIN  = 2'd2,
    RESP   = 2'd3
  } ewb_state_t;

  typedef logic [TAG_BITS-1:0]  tag_t;
  typedef logic [LINE_BITS-1:0] line_t;

  function automatic logic [31:0] line_addr(input tag_t tag);
    return {tag, {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/eviction_write_buffer_entry_array.sv
// FIFO of buffered dirty lines with a fully associative tag lookup used for
// read forwarding and write coalescing.
module ewb_entry_array
  import rv32i_types::*;
#(
  parameter  int DEPTH = 2,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  tag_t             i_lookup_tag,
  input  line_t            i_wdata,
  input  logic             i_enq,
  input  logic             i_coalesce,
  input  logic             i_pop,
  output logic             o_match,
  output line_t            o_match_data,
  output logic             o_full,
  output logic [CNT_W-1:0] o_count,
  output tag_t             o_head_tag,
  output line_t            o_head_data
);

  logic [DEPTH-1:0] r_valid;
  tag_t             r_tag  [DEPTH];
  line_t            r_data [DEPTH];
  logic [IDX_W-1:0] r_head;
  logic [IDX_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic [DEPTH-1:0] w_match_vec;
  logic [IDX_W-1:0] w_match_idx;

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(DEPTH - 1)) ? '0 : p + IDX_W'(1);
  endfunction

  always_comb begin
    w_match_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_match_vec[i] = r_valid[i] && (r_tag[i] == i_lookup_tag);
    end
  end

  // Coalescing keeps tags unique, so at most one bit of the vector is set.
  always_comb begin
    w_match_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_match_vec[i]) w_match_idx = IDX_W'(i);
    end
  end

  assign o_match      = |w_match_vec;
  assign o_match_data = r_data[w_match_idx];
  assign o_full       = (r_count == CNT_W'(DEPTH));
  assign o_count      = r_count;
  assign o_head_tag   = r_tag[r_head];
  assign o_head_data  = r_data[r_head];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_enq) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= next_ptr(r_tail);
      end
      if (i_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= next_ptr(r_head);
      end
      case ({i_enq, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Line storage carries no reset; validity alone decides what is live.
  always_ff @(posedge clk) begin
    if (i_enq) begin
      r_tag[r_tail]  <= i_lookup_tag;
      r_data[r_tail] <= i_wdata;
    end else if (i_coalesce) begin
      r_data[w_match_idx] <= i_wdata;
    end
  end

endmodule

// File: rtl/eviction_write_buffer.sv
// Eviction write buffer: absorbs L2 writebacks, forwards hits to reads and
// drains buffered lines to the cacheline adaptor while L2 is idle.
module eviction_write_buffer
  import rv32i_types::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          mem_address,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [LINE_BITS-1:0] mem_wdata,
  output logic [LINE_BITS-1:0] mem_rdata,
  output logic                 mem_resp,
  output logic [31:0]          pmem_address,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [LINE_BITS-1:0] pmem_wdata,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp
);

  ewb_state_t r_state;
  ewb_state_t w_next_state;
  line_t      r_rdata;

  logic             w_match;
  line_t            w_match_data;
  logic             w_full;
  logic [CNT_W-1:0] w_count;
  tag_t             w_head_tag;
  line_t            w_head_data;
  tag_t             w_req_tag;
  logic             w_enq;
  logic             w_coalesce;
  logic             w_pop;
  logic             w_ld_hit;
  logic             w_ld_mem;
  logic             w_unused_offset;

  assign w_req_tag       = mem_address[31:OFFSET_BITS];
  assign w_unused_offset = ^mem_address[OFFSET_BITS-1:0];

  ewb_entry_array #(.DEPTH(DEPTH)) u_array (
    .clk          (clk),
    .rst          (rst),
    .i_lookup_tag (w_req_tag),
    .i_wdata      (mem_wdata),
    .i_enq        (w_enq),
    .i_coalesce   (w_coalesce),
    .i_pop        (w_pop),
    .o_match      (w_match),
    .o_match_data (w_match_data),
    .o_full       (w_full),
    .o_count      (w_count),
    .o_head_tag   (w_head_tag),
    .o_head_data  (w_head_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  // Reads outrank writes, and any L2 request outranks a pending drain.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (mem_read) begin
          w_next_state = w_match ? RESP : RD_MEM;
        end else if (mem_write) begin
          w_next_state = (w_match || !w_full) ? RESP : DRAIN;
        end else if (w_count != '0) begin
          w_next_state = DRAIN;
        end
      end
      RD_MEM:  if (pmem_resp) w_next_state = RESP;
      DRAIN:   if (pmem_resp) w_next_state = IDLE;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    w_enq        = 1'b0;
    w_coalesce   = 1'b0;
    w_pop        = 1'b0;
    w_ld_hit     = 1'b0;
    w_ld_mem     = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem_read) begin
          w_ld_hit = w_match;
        end else if (mem_write) begin
          w_coalesce = w_match;
          w_enq      = !w_match && !w_full;
        end
      end
      RD_MEM: begin
        pmem_read    = 1'b1;
        pmem_address = line_addr(w_req_tag);
        w_ld_mem     = pmem_resp;
      end
      DRAIN: begin
        pmem_write   = 1'b1;
        pmem_address = line_addr(w_head_tag);
        pmem_wdata   = w_head_data;
        w_pop        = pmem_resp;
      end
      RESP:    mem_resp = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst)          r_rdata <= '0;
    else if (w_ld_hit) r_rdata <= w_match_data;
    else if (w_ld_mem) r_rdata <= pmem_rdata;
  end

  assign mem_rdata = r_rdata;

endmodule

// File: tb/tb_eviction_write_buffer.sv
// Scenario bench for eviction_write_buffer with a behavioural adaptor model
// and a queue of expected memory-side transactions.
module tb_eviction_write_buffer;
  import rv32i_types::*;

  localparam int CLK_HALF = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  typedef struct packed {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } mem_op_t;

  mem_op_t      exp_ops[$];
  logic [255:0] exp_rd[$];
  int           n_vec = 0;
  int           n_err = 0;
  time          t_presp = 0;

  logic [255:0] dA = {8{32'hA0A0_0001}};
  logic [255:0] dB = {8{32'hB1B1_0002}};
  logic [255:0] dC = {8{32'hC2C2_0003}};
  logic [255:0] dD = {8{32'hD3D3_0004}};
  logic [255:0] dE = {8{32'hE4E4_0005}};
  logic [255:0] dF = {8{32'hF5F5_0006}};
  logic [255:0] dG = {8{32'h1717_0007}};
  logic [255:0] dH = {8{32'h2828_0008}};

  always #CLK_HALF clk = ~clk;

  eviction_write_buffer #(.DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always @(posedge clk) begin
    if (rst === 1'b1)
      assert (!(mem_read && mem_write))
      else $error("illegal request: mem_read and mem_write both high");
  end

  function automatic logic [255:0] line_of(input logic [31:0] addr);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = addr + 32'h0101_0101 * i;
    return d;
  endfunction

  function automatic mem_op_t op(input logic wr, input logic [31:0] addr,
                                 input logic [255:0] data);
    mem_op_t o;
    o.wr = wr; o.addr = addr; o.data = data;
    return o;
  endfunction

  // Adaptor: checks each transaction against the expected queue, requires
  // stable outputs while it is outstanding, then answers after 3 cycles.
  task automatic adaptor();
    mem_op_t      seen, exp;
    logic [289:0] held;
    bit           unstable;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && (pmem_read || pmem_write)) begin
        n_vec++;
        if (pmem_read && pmem_write) begin
          n_err++;
          $display("FAIL pmem_exclusive: read=%0b write=%0b, required not both", pmem_read, pmem_write);
        end
        seen = op(pmem_write, pmem_address, pmem_wdata);
        n_vec++;
        if (exp_ops.size() == 0) begin
          n_err++;
          $display("FAIL pmem_unexpected: wr=%0b addr=%h, required no transaction", seen.wr, seen.addr);
        end else begin
          exp = exp_ops.pop_front();
          if (seen !== exp) begin
            n_err++;
            $display("FAIL pmem_txn: got wr=%0b addr=%h data=%h, required wr=%0b addr=%h data=%h",
                     seen.wr, seen.addr, seen.data, exp.wr, exp.addr, exp.data);
          end
        end
        held = {pmem_read, pmem_write, pmem_address, pmem_wdata};
        unstable = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          if ({pmem_read, pmem_write, pmem_address, pmem_wdata} !== held) unstable = 1'b1;
        end
        n_vec++;
        if (unstable) begin
          n_err++;
          $display("FAIL pmem_stable: addr=%h changed during transaction, required stable %h",
                   pmem_address, held[287:256]);
        end
        pmem_rdata = pmem_read ? line_of(pmem_address) : '0;
        pmem_resp  = 1'b1;
        t_presp    = $time;
        @(negedge clk);
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
      end
    end
  endtask

  // Issue one L2 request starting just after a clock edge; exp_lat counts
  // falling edges until mem_resp (0 = unchecked).
  task automatic l2_req(input logic wr, input logic [31:0] addr, input logic [255:0] wdata,
                        input int exp_lat, input bit chk_miss, input string name);
    int           k;
    bit           seen;
    logic [255:0] e;
    mem_address = addr;
    mem_read    = !wr;
    mem_write   = wr;
    mem_wdata   = wr ? wdata : '0;
    seen = 1'b0;
    k    = 0;
    while (!seen && k < 200) begin
      @(negedge clk);
      k++;
      if (mem_resp === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s_resp: no mem_resp within %0d cycles, required a pulse", name, k);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      return;
    end
    if (exp_lat > 0) begin
      n_vec++;
      if (k !== exp_lat) begin
        n_err++;
        $display("FAIL %s_latency: got %0d, required %0d", name, k, exp_lat);
      end
    end
    if (chk_miss) begin
      n_vec++;
      if (($time - t_presp) !== 2 * CLK_HALF) begin
        n_err++;
        $display("FAIL %s_miss_latency: got %0t after pmem_resp, required %0d", name,
                 $time - t_presp, 2 * CLK_HALF);
      end
    end
    if (!wr) begin
      n_vec++;
      if (exp_rd.size() == 0) begin
        n_err++;
        $display("FAIL %s_rdata: got %h, required nothing queued", name, mem_rdata);
      end else begin
        e = exp_rd.pop_front();
        if (mem_rdata !== e) begin
          n_err++;
          $display("FAIL %s_rdata: got %h, required %h", name, mem_rdata, e);
        end
      end
    end
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    n_vec++;
    if (mem_resp !== 1'b0) begin
      n_err++;
      $display("FAIL %s_pulse: mem_resp=%0b one cycle later, required 0", name, mem_resp);
    end
  endtask

  task automatic check_count(input int exp, input string name);
    n_vec++;
    if (dut.w_count !== 2'(exp)) begin
      n_err++;
      $display("FAIL %s_count: got %0d, required %0d", name, dut.w_count, exp);
    end
  endtask

  task automatic wait_drained(input string name);
    int k = 0;
    while ((exp_ops.size() != 0 || dut.w_count != 0 || pmem_read || pmem_write) && k < 300) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (exp_ops.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: %0d expected transactions never seen, required 0", name, exp_ops.size());
    end
    check_count(0, name);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_read = 1'b1; mem_write = 1'b0;
    mem_address = 32'h0000_1234; mem_wdata = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    repeat (2) begin
      @(negedge clk);
      n_vec++;
      if ({mem_resp, pmem_read, pmem_write} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_ctrl: resp/rd/wr=%b, required 000", {mem_resp, pmem_read, pmem_write});
      end
      n_vec++;
      if (mem_rdata !== '0 || pmem_address !== '0 || pmem_wdata !== '0) begin
        n_err++;
        $display("FAIL reset_data: rdata=%h addr=%h, required zeros", mem_rdata, pmem_address);
      end
      check_count(0, "reset");
    end
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    rst      = 1'b1;
  endtask

  task automatic test_write_drain();
    exp_ops.push_back(op(1'b1, 32'h0000_0100, dA));
    l2_req(1'b1, 32'h0000_0100, dA, 2, 1'b0, "wr_100");
    wait_drained("write_drain");
  endtask

  task automatic test_read_forward();
    exp_ops.push_back(op(1'b1, 32'h0000_0200, dB));
    l2_req(1'b1, 32'h0000_0200, dB, 2, 1'b0, "wr_200");
    exp_rd.push_back(dB);
    l2_req(1'b0, 32'h0000_0204, '0, 2, 1'b0, "rd_fwd_204");
    wait_drained("read_forward");
  endtask

  task automatic test_coalesce();
    exp_ops.push_back(op(1'b1, 32'h0000_0300, dD));
    l2_req(1'b1, 32'h0000_0300, dC, 2, 1'b0, "wr_300_c");
    l2_req(1'b1, 32'h0000_0300, dD, 2, 1'b0, "wr_300_d");
    check_count(1, "coalesce");
    wait_drained("coalesce");
  endtask

  task automatic test_back_to_back_full();
    exp_ops.push_back(op(1'b1, 32'h0000_0400, dE));
    exp_ops.push_back(op(1'b1, 32'h0000_0500, dF));
    exp_ops.push_back(op(1'b1, 32'h0000_0600, dG));
    l2_req(1'b1, 32'h0000_0400, dE, 2, 1'b0, "wr_400");
    l2_req(1'b1, 32'h0000_0500, dF, 2, 1'b0, "wr_500");
    l2_req(1'b1, 32'h0000_0600, dG, 0, 1'b0, "wr_600");
    check_count(2, "full");
    wait_drained("full");
  endtask

  task automatic test_read_priority();
    exp_ops.push_back(op(1'b0, 32'h0000_1000, '0));
    exp_ops.push_back(op(1'b1, 32'h0000_0700, dH));
    l2_req(1'b1, 32'h0000_0700, dH, 2, 1'b0, "wr_700");
    exp_rd.push_back(line_of(32'h0000_1000));
    l2_req(1'b0, 32'h0000_1004, '0, 0, 1'b1, "rd_miss_1004");
    wait_drained("read_priority");
  endtask

  initial begin
    test_reset();
    fork
      adaptor();
    join_none
    test_write_drain();
    test_read_forward();
    test_coalesce();
    test_back_to_back_full();
    test_read_priority();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/eviction_write_buffer.md
Name: eviction_write_buffer

Overview:
- Sits between l2_cache (upstream) and cacheline_adaptor (downstream).
- Absorbs dirty-line writebacks from L2 so that L2 miss reads reach memory without waiting behind a writeback burst.
- Buffered lines drain to memory when the L2 side is idle.
- Reads that match a buffered line are forwarded from the buffer and never reach memory.

Parameters:
DEPTH, 2, number of 256-bit line entries; power of 2, at least 1.

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-low reset
mem_address  input  32  L2 request address; bits [4:0] ignored
mem_read  input  1  L2 line read request, held until mem_resp
mem_write  input  1  L2 line writeback request, held until mem_resp
mem_wdata  input  256  writeback line
mem_rdata  output  256  read line; valid while mem_resp=1
mem_resp  output  1  one-cycle completion pulse to L2
pmem_address  output  32  adaptor address, bits [4:0]=0
pmem_read  output  1  adaptor read, held until pmem_resp
pmem_write  output  1  adaptor write, held until pmem_resp
pmem_wdata  output  256  head entry line
pmem_rdata  input  256  adaptor read line
pmem_resp  input  1  adaptor completion

Behaviour:
- Entry storage: valid bit, tag = addr[31:5], 256-bit data. FIFO order via head/tail pointers and a count (0..DEPTH). Pointers wrap modulo DEPTH.
- Match: a valid entry whose tag equals mem_address[31:5]. Write coalescing guarantees at most one match.
- States: IDLE, RD_MEM, DRAIN, RESP. Requests are evaluated only in IDLE.
- IDLE, in priority order:
  - mem_read with match: latch entry data into the rdata register, go to RESP.
  - mem_read with no match: go to RD_MEM.
  - mem_write with match: overwrite that entry's data in place (no count change), go to RESP.
  - mem_write, no match, not full: enqueue at tail, count+1, go to RESP.
  - mem_write, no match, full: go to DRAIN; the write stays pending and is re-evaluated in IDLE afterwards.
  - No request and count>0: go to DRAIN.
  - Otherwise: stay in IDLE.
- RD_MEM:
  - pmem_read=1, pmem_address = {mem_address[31:5],5'b0}.
  - On pmem_resp: latch pmem_rdata into the rdata register, go to RESP.
- DRAIN:
  - pmem_write=1, pmem_address = {head tag,5'b0}, pmem_wdata = head data.
  - On pmem_resp: invalidate head, head+1, count-1, go to IDLE.
  - A DRAIN is never aborted. A read arriving during DRAIN waits for the drain to complete.
- RESP:
  - mem_resp=1 for exactly one cycle, mem_rdata = rdata register; then go to IDLE.
  - L2 drops its request on the edge that samples mem_resp; requests are ignored during RESP.
- Latency:
  - read hit or write accept: mem_resp 2 cycles after the request is first seen in IDLE.
  - read miss: mem_resp 1 cycle after pmem_resp.
- pmem_read and pmem_write are never both 1. mem_read and mem_write both 1 is illegal; the bench checks this with an assertion.
- pmem_* outputs stay stable for the full transaction; pmem_wdata is 0 outside DRAIN.
- Reset (rst=0 at a clock edge):
  - State goes to IDLE; count, head and tail go to 0; all valid bits clear.
  - mem_resp, pmem_read and pmem_write are 0 from the next cycle. mem_rdata, pmem_address and pmem_wdata reset to 0.
  - Reset mid-operation discards buffered lines and aborts any pmem transaction; the adaptor shares rst.

Decomposition:
- Shared package (rv32i_types): ewb_state_t enum {IDLE, RD_MEM, DRAIN, RESP}; LINE_BITS=256; OFFSET_BITS=5; TAG_BITS=27.
- Sub-module ewb_entry_array:
  - DEPTH tag/data/valid entries with head/tail/count.
  - Combinational match vector and match index.
  - Enqueue, coalesce-write and pop controls.
- Top level holds the FSM, the rdata register and the pmem output muxing.

Test Plan:
1. Hold rst=0 for 2 cycles with mem_read=1 -> mem_resp, pmem_read and pmem_write stay 0 throughout; count=0.
2. Write 0x100 with data A -> mem_resp pulse 2 cycles later. Then with L2 idle: pmem_write=1, pmem_address=0x100, pmem_wdata=A until pmem_resp; count returns to 0.
3. Write 0x200 data B, then immediately read 0x204 -> mem_resp with mem_rdata=B; pmem_read never asserted.
4. Back-to-back writes to 0x300 with C then D -> count=1; the only drain is pmem_write 0x300 with D.
5. DEPTH=2: write 0x400, write 0x500, write 0x600 back-to-back -> first memory activity is pmem_write 0x400; then 0x600 is accepted (count=2); later drains go 0x500 then 0x600.
6. Buffer holds 0x700 and L2 reads 0x1004 in the same cycle the buffer becomes eligible to drain -> pmem_read at 0x1000 before any pmem_write; mem_rdata = pmem_rdata; drain of 0x700 follows.
